// File: rtl/benes_rx_unpack.sv
// Benes network receive unpacker: decodes tagged lanes back into
// source-ordered slots with route map, error flags and error counter.
//
// Ports:
//   clk, rst                 clock, sync active-high reset
//   in_valid/in_ready        input word handshake
//   in_lanes, expected_mask  tagged network word, expected sources
//   out_valid/out_ready      result handshake
//   out_data, out_src_mask   source-ordered payload and received mask
//   out_route                lane index per source
//   err_dup/missing/unexp    per-word error flags
//   err_count                saturating count of errored words
module benes_rx_unpack #(
  parameter int DATA_W = 16,
  parameter int PORTS  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PORTS*(DATA_W+4)-1:0] in_lanes,
  input  logic [PORTS-1:0]          expected_mask,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PORTS*DATA_W-1:0]   out_data,
  output logic [PORTS-1:0]          out_src_mask,
  output logic [PORTS*3-1:0]        out_route,
  output logic                      err_dup,
  output logic                      err_missing,
  output logic                      err_unexpected,
  output logic [7:0]                err_count
);

  localparam int LW = DATA_W + 4;
  localparam int TW = PORTS * LW;
  localparam int DW = PORTS * DATA_W;
  localparam int RW = PORTS * 3;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   lanes_q, lanes_d;
  logic [PORTS-1:0] exp_q, exp_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   data_q, data_d;
  logic [PORTS-1:0] mask_q, mask_d;
  logic [RW-1:0]   route_q, route_d;
  logic            dup_q, dup_d;
  logic            miss_q, miss_d;
  logic            unexp_q, unexp_d;
  logic [7:0]      cnt_q, cnt_d;

  logic [DW-1:0]   dec_data;
  logic [PORTS-1:0] dec_mask;
  logic [RW-1:0]   dec_route;
  logic            dec_dup;
  logic            dec_bad;
  logic [LW-1:0]   lane;
  logic [3:0]      tag;

  // Ascending lane scan: the first lane to claim a source keeps it,
  // so the lowest lane index wins on duplicates.
  always_comb begin
    dec_data  = '0;
    dec_mask  = '0;
    dec_route = '0;
    dec_dup   = 1'b0;
    dec_bad   = 1'b0;
    lane      = '0;
    tag       = '0;
    for (int k = 0; k < PORTS; k++) begin
      lane = lanes_q[TW-1-LW*k -: LW];
      tag  = lane[3:0];
      if (!tag[3]) begin
        if (dec_mask[tag[2:0]]) begin
          dec_dup = 1'b1;
        end else begin
          dec_mask[tag[2:0]] = 1'b1;
          dec_data[DW-1-DATA_W*int'(tag[2:0]) -: DATA_W] =
            lane[LW-1 -: DATA_W];
          dec_route[RW-1-3*int'(tag[2:0]) -: 3] = 3'(k);
        end
      end else if (tag != 4'hF) begin
        dec_bad = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    lanes_d     = lanes_q;
    exp_d       = exp_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    data_d      = data_q;
    mask_d      = mask_q;
    route_d     = route_q;
    dup_d       = dup_q;
    miss_d      = miss_q;
    unexp_d     = unexp_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          lanes_d    = in_lanes;
          exp_d      = expected_mask;
          in_ready_d = 1'b0;
          state_d    = DECODE;
        end
      end
      DECODE: begin
        data_d      = dec_data;
        mask_d      = dec_mask;
        route_d     = dec_route;
        dup_d       = dec_dup;
        miss_d      = |(exp_q & ~dec_mask);
        unexp_d     = dec_bad | (|(dec_mask & ~exp_q));
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
          if ((dup_q | miss_q | unexp_q) && cnt_q != 8'hFF)
            cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lanes_q     <= '0;
      exp_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      mask_q      <= '0;
      route_q     <= '0;
      dup_q       <= 1'b0;
      miss_q      <= 1'b0;
      unexp_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      lanes_q     <= lanes_d;
      exp_q       <= exp_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      route_q     <= route_d;
      dup_q       <= dup_d;
      miss_q      <= miss_d;
      unexp_q     <= unexp_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign out_data       = data_q;
  assign out_src_mask   = mask_q;
  assign out_route      = route_q;
  assign err_dup        = dup_q;
  assign err_missing    = miss_q;
  assign err_unexpected = unexp_q;
  assign err_count      = cnt_q;

endmodule

// File: doc/benes_rx_unpack.md
BENES_RX_UNPACK -- requirements
Module: benes_rx_unpack

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning the payload width per lane; the tag width is fixed at 4 and the lane width is DATA_W+4.
REQ-002 SHALL have parameter PORTS, default 8, meaning the number of lanes and sources; only 8 is supported.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: in_lanes and expected_mask are valid this cycle.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-007 SHALL have port in_lanes, input, 160 bits: network output word; lane k occupies [159-20k -: 20], with data in [19:4] and source tag in [3:0].
REQ-008 SHALL have port expected_mask, input, 8 bits: bit s set means source s is expected in this word.
REQ-009 SHALL have port out_valid, output, 1 bit: result outputs are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port out_data, output, 128 bits: payload reordered by source; source s occupies [127-16s -: 16].
REQ-012 SHALL have port out_src_mask, output, 8 bits: bit s set means source s was received.
REQ-013 SHALL have port out_route, output, 24 bits: lane index that carried source s, held in [23-3s -: 3].
REQ-014 SHALL have port err_dup, output, 1 bit: a source tag appeared on more than one lane.
REQ-015 SHALL have port err_missing, output, 1 bit: an expected source was absent.
REQ-016 SHALL have port err_unexpected, output, 1 bit: an unexpected source was received, or a reserved tag 0x8-0xE was seen.
REQ-017 SHALL have port err_count, output, 8 bits: saturating count of delivered words with any error flag set.

Function
REQ-018 SHALL implement FSM states IDLE, DECODE and HOLD.
REQ-019 IDLE: in_ready=1; in_valid=1 SHALL capture in_lanes and expected_mask into registers and move the FSM to DECODE.
REQ-020 DECODE: in_ready=0; the block SHALL decode all 8 lanes in one cycle, register the results and move to HOLD.
REQ-021 HOLD: out_valid=1 and in_ready=0; out_ready=1 SHALL return the FSM to IDLE, with out_valid=0 on the next cycle.
REQ-022 Latency SHALL be exactly 2 cycles from the accepting edge to the first cycle with out_valid=1; throughput is one word per 3 cycles when out_ready is held high.
REQ-023 Lane decode, tag 0x0-0x7 (source s): the block SHALL write the lane data to slot s, set out_src_mask[s] and set out_route[s] to the lane index.
REQ-024 Lane decode, tag 0xF: idle lane; the block SHALL ignore it with no error.
REQ-025 Lane decode, tag 0x8-0xE: the block SHALL set err_unexpected and discard the lane data.
REQ-026 Duplicate source tags: the lowest lane index SHALL win, and err_dup SHALL be set.
REQ-027 Unfilled slots SHALL read 0 in out_data, and their out_route field SHALL read 3'b000.
REQ-028 err_missing SHALL equal |(expected_mask & ~out_src_mask).
REQ-029 err_unexpected SHALL also assert when (out_src_mask & ~expected_mask) is nonzero.
REQ-030 err_count SHALL increment once on each HOLD-to-IDLE handshake where any error flag is 1, and SHALL saturate at 255 without wrap.
REQ-031 In HOLD, all result outputs SHALL stay stable until out_ready=1; in_valid SHALL be ignored.
REQ-032 In DECODE, in_valid SHALL be ignored, so no word is captured.
REQ-033 All outputs SHALL be registered, with no combinational path from in_lanes to any output.

Reset
REQ-034 rst=1 SHALL force the FSM to IDLE and clear these outputs to 0: out_valid, out_data, out_src_mask, out_route, all error flags and err_count; in_ready SHALL be 1 from the first cycle after reset.
REQ-035 rst in DECODE or HOLD SHALL abort the word without producing an output or incrementing err_count; rst SHALL take priority over every other input.

Verification
REQ-036 Identity word: lane k = {16'h1000+k, k}, expected_mask=8'hFF -> 2 cycles later out_valid=1, out_data slot s=16'h1000+s, out_src_mask=8'hFF, out_route={0,1,...,7}, no errors.
REQ-037 Reversed word: lane k tag = 7-k, data 16'hA0A0+k -> slot s=16'hA0A7-s, out_route[s]=7-s.
REQ-038 Disabled ports: lanes 6 and 7 tag 0xF, expected_mask=8'h3F -> out_src_mask=8'h3F, slots 6 and 7 = 0, no errors; the same word with expected_mask=8'hFF -> err_missing=1 and err_count increments by 1.
REQ-039 Duplicate and reserved tags: lanes 2 and 5 both tag 3, lane 7 tag 0xA -> slot 3 holds lane 2 data, out_route[3]=2, err_dup=1, err_unexpected=1.
REQ-040 Backpressure and reset: out_ready=0 for 5 cycles with a second in_valid pulsed -> outputs stable and in_ready=0 throughout; then rst in DECODE -> out_valid never asserts and err_count is unchanged.
REQ-041 Saturation: 260 consecutive error words -> err_count=255.
